// File: rtl/push_debouncer_pkg.sv
// Shared debouncer types and constants, also used by the game-state logic.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package push_debouncer_pkg;

    // Default qualification length: 10 ms at 50 MHz.
    localparam int unsigned PUSH_STABLE_CYCLES = 500000;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        PRESS_WAIT = 2'b01,
        HELD       = 2'b10,
        REL_WAIT   = 2'b11
    } state_t;

endpackage

// File: rtl/push_debouncer.sv
// Debounces one synchronized pushbutton into a held level plus one-cycle press/release pulses.
// Latency: level/press change after the STABLE_CYCLES-th identical sample edge (registered outputs).
// Backpressure: none; one sample is taken every clock and no input is ever stalled.
// Optional macro PUSH_DEBOUNCER_RELEASE_PULSE_EN builds the release pulse register;
// without it release_pulse is tied low.
module push_debouncer
    import push_debouncer_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = PUSH_STABLE_CYCLES,
    parameter int unsigned CNT_W         = 19
) (
    input  logic clk,
    input  logic rst,
    input  logic sypush,
    output logic level,
    output logic press,
    output logic release_pulse
);

    // Count value on the last sample of a qualification window.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // FSM and stability counter; pulses default low so each lasts one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
`ifdef PUSH_DEBOUNCER_RELEASE_PULSE_EN
            release_pulse <= 1'b0;
`endif
        end else begin
            press <= 1'b0;
`ifdef PUSH_DEBOUNCER_RELEASE_PULSE_EN
            release_pulse <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (sypush) begin
                        state <= PRESS_WAIT;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sypush) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= HELD;
                        cnt   <= '0;
                        level <= 1'b1;
                        press <= 1'b1;
                    end else begin
                        cnt   <= cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!sypush) begin
                        state <= REL_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end
                REL_WAIT: begin
                    if (sypush) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        level <= 1'b0;
`ifdef PUSH_DEBOUNCER_RELEASE_PULSE_EN
                        release_pulse <= 1'b1;
`endif
                    end else begin
                        cnt   <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    // Corrupted state: fall back to a clean released condition.
                    state <= IDLE;
                    cnt   <= '0;
                    level <= 1'b0;
                    press <= 1'b0;
                end
            endcase
        end
    end

`ifndef PUSH_DEBOUNCER_RELEASE_PULSE_EN
    assign release_pulse = 1'b0;
`endif

endmodule
